// File: rtl/reg_writeback.sv
// Writeback stage: merges fixed-latency ALU results with queued load results into the
// single register file write port, and tracks outstanding loads for decode hazard checks.
module reg_writeback #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        alu_hold,
  output logic        write_enable,
  output logic [4:0]  write_address,
  output logic [31:0] write_value
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

  logic [4:0]    fifo_rd   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [31:0]   pending;
  logic [31:0]   pend_set;
  logic [31:0]   pend_clr;
  logic [31:0]   pend_next;
  logic          out_is_load;
  logic [7:0]    starve;
  logic [7:0]    starve_next;

  // Handshake: readiness looks only at the start-of-cycle count, never at a same-cycle pop.
  assign ld_ready = rst_n && (count < DEPTH_C);
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_value   <= '0;
      out_is_load   <= 1'b0;
    end else if (alu_valid) begin
      write_enable  <= (alu_rd != 5'd0);
      write_address <= alu_rd;
      write_value   <= alu_result;
      out_is_load   <= 1'b0;
    end else if (pop) begin
      write_enable  <= (fifo_rd[rd_ptr] != 5'd0);
      write_address <= fifo_rd[rd_ptr];
      write_value   <= fifo_data[rd_ptr];
      out_is_load   <= 1'b1;
    end else begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_value   <= '0;
      out_is_load   <= 1'b0;
    end
  end

  // A load's pending bit clears once its write has sat on the output stage for a cycle;
  // a new issue to the same rd on that edge keeps the bit set.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (ld_issue) pend_set[ld_issue_rd] = 1'b1;
    if (write_enable && out_is_load) pend_clr[write_address] = 1'b1;
    pend_next = ((pending & ~pend_clr) | pend_set) & ~32'h1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_next;
  end

  assign hazard = ((rs1 != 5'd0) && pending[rs1]) || ((rs2 != 5'd0) && pending[rs2]);

  always_comb begin
    starve_next = starve;
    if (pop || (count == '0))  starve_next = '0;
    else if (starve < LIMIT_C) starve_next = starve + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve   <= '0;
      alu_hold <= 1'b0;
    end else begin
      starve   <= starve_next;
      alu_hold <= pop ? 1'b0 : (alu_hold || (starve_next == LIMIT_C));
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writes are queued at issue time and a
// negedge monitor compares every write the DUT presents; cycle-exact checks run inline.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_result = '0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        hazard;
  logic        alu_hold;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_value;

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;

  reg_writeback #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .rs1(rs1), .rs2(rs2), .hazard(hazard), .alu_hold(alu_hold),
    .write_enable(write_enable), .write_address(write_address), .write_value(write_value)
  );

  always #5 clk = ~clk;

  // Monitor: every presented write must match the head of the expected queue.
  always @(negedge clk) begin
    if (write_enable) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got addr %0d value %h, expected no write",
                 write_address, write_value);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({write_address, write_value} !== mon_exp) begin
          fails++;
          $display("FAIL wb_data: got addr %0d value %h, expected addr %0d value %h",
                   write_address, write_value, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_hold", 32'(alu_hold), 32'd0);
    cyc(); rst_n = 1'b1;
    @(negedge clk); chk("ready_after_reset", 32'(ld_ready), 32'd1);

    // ALU only: one-cycle latency, single write
    cyc(); alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clk); chk("alu_we_issue_cycle", 32'(write_enable), 32'd0);
    cyc(); alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    @(negedge clk); chk("alu_we_next", 32'(write_enable), 32'd1);
    chk("alu_addr", 32'(write_address), 32'd5);
    cyc();
    @(negedge clk); chk("alu_we_after", 32'(write_enable), 32'd0);

    // Load path with hazard tracking
    cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd7; rs1 = 5'd7;
    cyc(); ld_issue = 1'b0;
    @(negedge clk); chk("hazard_rs1", 32'(hazard), 32'd1);
    cyc(); rs1 = '0; rs2 = 5'd7;
    @(negedge clk); chk("hazard_rs2", 32'(hazard), 32'd1);
    cyc(); rs2 = '0; rs1 = 5'd7; ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12345678;
    exp_q.push_back({5'd7, 32'h12345678});
    @(negedge clk); chk("ld_ready_handshake", 32'(ld_ready), 32'd1);
    cyc(); ld_valid = 1'b0;
    @(negedge clk); chk("ld_we_t1", 32'(write_enable), 32'd0);
    cyc();
    @(negedge clk); chk("ld_we_t2", 32'(write_enable), 32'd1);
    chk("hazard_during_write", 32'(hazard), 32'd1);
    cyc();
    @(negedge clk); chk("hazard_cleared", 32'(hazard), 32'd0);
    chk("ld_we_t3", 32'(write_enable), 32'd0);
    rs1 = '0;

    // FIFO full while ALU (rd=0) holds the port
    cyc(); alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'hA0000000 + 32'(i);
      exp_q.push_back({5'(10 + i), 32'hA0000000 + 32'(i)});
      @(negedge clk); chk($sformatf("fill_ready_%0d", i), 32'(ld_ready), 32'd1);
      cyc();
    end
    ld_rd = 5'd14; ld_data = 32'hA0000004;
    @(negedge clk); chk("full_ready_0", 32'(ld_ready), 32'd0);
    cyc();
    @(negedge clk); chk("full_ready_1", 32'(ld_ready), 32'd0);
    cyc(); alu_valid = 1'b0; alu_result = '0;
    @(negedge clk); chk("ready_in_pop_cycle", 32'(ld_ready), 32'd0);
    cyc();
    @(negedge clk); chk("ready_after_pop", 32'(ld_ready), 32'd1);
    exp_q.push_back({5'd14, 32'hA0000004});
    for (int i = 0; i < 4; i++) begin
      if (i == 0) chk("drain_we_0", 32'(write_enable), 32'd1);
      cyc(); ld_valid = 1'b0;
      @(negedge clk); chk($sformatf("drain_we_%0d", i + 1), 32'(write_enable), 32'd1);
    end
    cyc();
    @(negedge clk); chk("drain_idle", 32'(write_enable), 32'd0);

    // Starvation: one queued load behind a constant ALU stream
    cyc(); alu_valid = 1'b1; alu_rd = 5'd0; ld_valid = 1'b1; ld_rd = 5'd15; ld_data = 32'h55;
    exp_q.push_back({5'd15, 32'h55});
    cyc(); ld_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); chk($sformatf("hold_low_%0d", k), 32'(alu_hold), 32'd0);
      cyc();
    end
    @(negedge clk); chk("hold_rise", 32'(alu_hold), 32'd1);
    cyc();
    @(negedge clk); chk("hold_stays", 32'(alu_hold), 32'd1);
    cyc(); alu_valid = 1'b0;
    @(negedge clk); chk("hold_pop_cycle", 32'(alu_hold), 32'd1);
    chk("starve_we_pop_cycle", 32'(write_enable), 32'd0);
    cyc();
    @(negedge clk); chk("hold_fall", 32'(alu_hold), 32'd0);
    chk("starve_we", 32'(write_enable), 32'd1);

    // Load to x0 is consumed silently
    cyc(); ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hBAD0BAD0;
    cyc(); ld_valid = 1'b0;
    cyc();
    @(negedge clk); chk("x0_we", 32'(write_enable), 32'd0);

    // Re-issue of rd 9 on the edge its prior load clears: set wins
    cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd9;
    cyc(); ld_issue = 1'b0; rs1 = 5'd9;
    @(negedge clk); chk("race_hazard_set", 32'(hazard), 32'd1);
    cyc(); ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99990009;
    exp_q.push_back({5'd9, 32'h99990009});
    cyc(); ld_valid = 1'b0;
    cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd9;
    @(negedge clk); chk("race_we", 32'(write_enable), 32'd1);
    cyc(); ld_issue = 1'b0;
    @(negedge clk); chk("race_hazard_held_0", 32'(hazard), 32'd1);
    cyc();
    @(negedge clk); chk("race_hazard_held_1", 32'(hazard), 32'd1);
    rs1 = '0;

    // Asynchronous reset with three queued loads, pending bits, and a write on the outputs
    cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd20; alu_valid = 1'b1; alu_rd = 5'd0; rs1 = 5'd20;
    cyc(); ld_issue_rd = 5'd21; ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'hC0;
    cyc(); ld_issue = 1'b0; ld_rd = 5'd21; ld_data = 32'hC1;
    cyc(); ld_rd = 5'd22; ld_data = 32'hC2; alu_rd = 5'd3; alu_result = 32'h33; rs2 = 5'd21;
    @(negedge clk); chk("pre_reset_hazard", 32'(hazard), 32'd1);
    cyc(); ld_valid = 1'b0; alu_rd = 5'd0; alu_result = '0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(write_enable), 32'd0);
    chk("async_rst_addr", 32'(write_address), 32'd0);
    chk("async_rst_value", write_value, 32'd0);
    chk("async_rst_ready", 32'(ld_ready), 32'd0);
    chk("async_rst_hazard", 32'(hazard), 32'd0);
    chk("async_rst_hold", 32'(alu_hold), 32'd0);
    alu_valid = 1'b0;
    cyc(); cyc(); rst_n = 1'b1;
    @(negedge clk); chk("post_rst_ready", 32'(ld_ready), 32'd1);
    chk("post_rst_hazard", 32'(hazard), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      @(negedge clk); chk($sformatf("post_rst_we_%0d", i), 32'(write_enable), 32'd0);
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
